// File: rtl/xor_share_sched.sv
// Round-robin scheduler sharing one strobed XOR cell between requesters.
// One operation in flight: IDLE -> SETUP -> STROBE -> WAIT -> RESP.
module xor_share_sched #(
  parameter int N_REQ   = 4,
  parameter int RES_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic [N_REQ-1:0] req_a,
  input  logic [N_REQ-1:0] req_b,
  output logic [N_REQ-1:0] req_ready,
  output logic             xor_a,
  output logic             xor_b,
  output logic             xor_clk,
  input  logic             xor_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2:0]       rsp_id,
  output logic             rsp_data,
  output logic             busy,
  output logic [7:0]       done_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] last_grant;
  logic [2:0] grant;
  logic       gnt_ok;
  logic [2:0] op_id;
  logic       op_a;
  logic       op_b;
  logic [3:0] cnt;
  logic [7:0] done_q;
  logic       hs;
  logic [7:0] vpad;
  logic [7:0] apad;
  logic [7:0] bpad;
  logic [7:0] rdy8;
  int         sum;

  assign vpad = 8'(req_valid);
  assign apad = 8'(req_a);
  assign bpad = 8'(req_b);

  // Descending scan so the lowest offset from last_grant+1 wins.
  always_comb begin
    grant  = '0;
    gnt_ok = 1'b0;
    sum    = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = (int'(last_grant) + 1 + k) % N_REQ;
      if (vpad[3'(sum)]) begin
        grant  = 3'(sum);
        gnt_ok = 1'b1;
      end
    end
  end

  assign hs = rst_n && (state == S_IDLE) && gnt_ok;
  assign rdy8 = hs ? (8'd1 << grant) : 8'd0;
  assign req_ready = rdy8[N_REQ-1:0];
  assign busy = (state != S_IDLE);
  assign done_cnt = done_q;

  always_comb begin
    state_nxt = state;
    xor_a     = 1'b0;
    xor_b     = 1'b0;
    xor_clk   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hs) state_nxt = S_SETUP;
      end
      S_SETUP: begin
        xor_a     = op_a;
        xor_b     = op_b;
        state_nxt = S_STROBE;
      end
      S_STROBE: begin
        xor_a     = op_a;
        xor_b     = op_b;
        xor_clk   = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        xor_a = op_a;
        xor_b = op_b;
        if (cnt == 4'd0) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 3'(N_REQ - 1);
      cnt        <= 4'd0;
      done_q     <= 8'd0;
      rsp_id     <= 3'd0;
      rsp_data   <= 1'b0;
      op_id      <= 3'd0;
      op_a       <= 1'b0;
      op_b       <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        op_a       <= apad[grant];
        op_b       <= bpad[grant];
        op_id      <= grant;
        last_grant <= grant;
      end
      if (state == S_STROBE) cnt <= 4'(RES_LAT - 1);
      if (state == S_WAIT) begin
        if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rsp_data <= xor_out;
          rsp_id   <= op_id;
        end
      end
      if (state == S_RESP && rsp_ready) done_q <= done_q + 8'd1;
    end
  end

endmodule

// File: tb/tb_xor_share_sched.sv
// Directed bench for xor_share_sched: two instances, RES_LAT 1 and 3.
// XOR cell model drives the true result only in the final WAIT cycle.
module tb_xor_share_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] rv, ra, rb, rdy;
  logic       xa, xb, xc, xo;
  logic       rr, rsv, rsd, bsy;
  logic [2:0] rid;
  logic [7:0] dc;

  logic [3:0] rv3, ra3, rb3, rdy3;
  logic       xa3, xb3, xc3, xo3;
  logic       rr3, rsv3, rsd3, bsy3;
  logic [2:0] rid3;
  logic [7:0] dc3;

  logic [3:0] t0, t3;
  logic       r0, r3;
  logic [3:0] xv;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  xor_share_sched #(.N_REQ(4), .RES_LAT(1)) u0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv), .req_a(ra), .req_b(rb),
    .req_ready(rdy),
    .xor_a(xa), .xor_b(xb), .xor_clk(xc),
    .xor_out(xo),
    .rsp_valid(rsv), .rsp_ready(rr),
    .rsp_id(rid), .rsp_data(rsd),
    .busy(bsy), .done_cnt(dc)
  );

  xor_share_sched #(.N_REQ(4), .RES_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(rv3), .req_a(ra3), .req_b(rb3),
    .req_ready(rdy3),
    .xor_a(xa3), .xor_b(xb3), .xor_clk(xc3),
    .xor_out(xo3),
    .rsp_valid(rsv3), .rsp_ready(rr3),
    .rsp_id(rid3), .rsp_data(rsd3),
    .busy(bsy3), .done_cnt(dc3)
  );

  // Cell models: result valid exactly RES_LAT cycles after the strobe.
  always @(posedge clk) begin
    if (xc) begin
      t0 <= 4'd1;
      r0 <= xa ^ xb;
    end else if (t0 != 4'd0) begin
      t0 <= t0 - 4'd1;
    end
    if (xc3) begin
      t3 <= 4'd3;
      r3 <= xa3 ^ xb3;
    end else if (t3 != 4'd0) begin
      t3 <= t3 - 4'd1;
    end
  end

  assign xo  = (t0 == 4'd1) ? r0 : ~r0;
  assign xo3 = (t3 == 4'd1) ? r3 : ~r3;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_op(input int r);
    int n;
    rv = 4'(1 << r);
    rr = 1'b1;
    tick();
    rv = 4'd0;
    n = 0;
    while (rsv !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("op_wait", 32'(n < 20), 32'd1);
    tick();
  endtask

  initial begin
    t0 = 4'd0; t3 = 4'd0; r0 = 1'b0; r3 = 1'b0;
    rst_n = 1'b0;
    rv = 4'b1111; ra = 4'd0; rb = 4'd0; rr = 1'b0;
    rv3 = 4'd0; ra3 = 4'd0; rb3 = 4'd0; rr3 = 1'b0;
    xv = 4'b0110;

    tick();
    tick();
    #1;
    chk("rst_ready", 32'(rdy), 32'd0);
    chk("rst_busy", 32'(bsy), 32'd0);
    chk("rst_rsv", 32'(rsv), 32'd0);
    chk("rst_xclk", 32'(xc), 32'd0);
    chk("rst_xab", 32'({xa, xb}), 32'd0);
    chk("rst_done", 32'(dc), 32'd0);
    chk("rst_rid", 32'(rid), 32'd0);
    chk("rst_rdata", 32'(rsd), 32'd0);

    rv = 4'd0;
    rst_n = 1'b1;
    tick();

    // single request, operand drop after handshake
    rv = 4'b0001; ra = 4'b0001; rb = 4'b0000;
    #1;
    chk("s_ready", 32'(rdy), 32'b0001);
    tick();
    rv = 4'd0; ra = 4'd0;
    #1;
    chk("s_setup_busy", 32'(bsy), 32'd1);
    chk("s_setup_x", 32'({xa, xb, xc}), 32'b100);
    chk("s_setup_rdy", 32'(rdy), 32'd0);
    tick();
    chk("s_strobe_x", 32'({xa, xb, xc}), 32'b101);
    tick();
    chk("s_wait_x", 32'({xa, xb, xc}), 32'b100);
    chk("s_wait_rsv", 32'(rsv), 32'd0);
    tick();
    chk("s_rsv", 32'(rsv), 32'd1);
    chk("s_rid", 32'(rid), 32'd0);
    chk("s_rdata", 32'(rsd), 32'd1);
    chk("s_resp_x", 32'({xa, xb, xc}), 32'd0);
    rr = 1'b1;
    tick();
    rr = 1'b0;
    #1;
    chk("s_done", 32'(dc), 32'd1);
    chk("s_idle_rsv", 32'(rsv), 32'd0);
    chk("s_idle_busy", 32'(bsy), 32'd0);

    // round-robin start after grant 0, then backpressure
    rv = 4'b0101; ra = 4'b0100; rb = 4'b0100;
    #1;
    chk("bp_grant", 32'(rdy), 32'b0100);
    tick();
    tick();
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rsv", 32'(rsv), 32'd1);
      chk("bp_rid", 32'(rid), 32'd2);
      chk("bp_rdata", 32'(rsd), 32'd0);
      chk("bp_rdy", 32'(rdy), 32'd0);
      chk("bp_busy", 32'(bsy), 32'd1);
      tick();
    end
    rr = 1'b1;
    rv = 4'd0;
    tick();
    rr = 1'b0;
    #1;
    chk("bp_done", 32'(dc), 32'd2);
    chk("bp_idle_rdy", 32'(rdy), 32'd0);

    // reset during WAIT
    rv = 4'b1000; ra = 4'b1000; rb = 4'b0000;
    #1;
    chk("rw_grant", 32'(rdy), 32'b1000);
    tick();
    rv = 4'd0;
    tick();
    tick();
    chk("rw_wait_x", 32'({xa, xc}), 32'b10);
    rst_n = 1'b0;
    tick();
    #1;
    chk("rw_busy", 32'(bsy), 32'd0);
    chk("rw_rsv", 32'(rsv), 32'd0);
    chk("rw_x", 32'({xa, xb, xc}), 32'd0);
    chk("rw_done", 32'(dc), 32'd0);
    chk("rw_rid", 32'(rid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rw_after_rsv", 32'(rsv), 32'd0);
    chk("rw_after_busy", 32'(bsy), 32'd0);

    // fairness with everyone valid, rsp_ready tied high
    rv = 4'b1111; ra = 4'b0101; rb = 4'b0011; rr = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("f_grant", 32'(rdy), 32'(1 << (k % 4)));
      tick();
      tick();
      tick();
      tick();
      chk("f_rsv", 32'(rsv), 32'd1);
      chk("f_rid", 32'(rid), 32'(k % 4));
      chk("f_rdata", 32'(rsd), 32'(xv[k % 4]));
      tick();
    end
    rv = 4'd0;
    #1;
    chk("f_done", 32'(dc), 32'd5);

    // RES_LAT = 3 instance
    rv3 = 4'b0010; ra3 = 4'b0010; rb3 = 4'b0000;
    #1;
    chk("l3_grant", 32'(rdy3), 32'b0010);
    tick();
    rv3 = 4'd0;
    tick();
    chk("l3_strobe", 32'(xc3), 32'd1);
    for (int c = 3; c < 6; c++) begin
      tick();
      chk("l3_wait_rsv", 32'(rsv3), 32'd0);
      chk("l3_wait_x", 32'({xa3, xc3}), 32'b10);
    end
    tick();
    chk("l3_rsv", 32'(rsv3), 32'd1);
    chk("l3_rid", 32'(rid3), 32'd1);
    chk("l3_rdata", 32'(rsd3), 32'd1);
    rr3 = 1'b1;
    tick();
    rr3 = 1'b0;
    chk("l3_done", 32'(dc3), 32'd1);

    // done_cnt wrap
    for (int i = 0; i < 250; i++) do_op(0);
    chk("w_255", 32'(dc), 32'd255);
    do_op(0);
    chk("w_wrap", 32'(dc), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xor_share_sched.md
XOR_SHARE_SCHED -- requirements
Module: xor_share_sched

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters sharing one basic_xor cell (2..8).
REQ-002 Parameter RES_LAT, default 1, cycles from xor_clk strobe to xor_out valid (1..15).
REQ-003 clk  input  1  single block clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  N_REQ  per-requester operation request.
REQ-006 req_a  input  N_REQ  per-requester operand a, bit i for requester i.
REQ-007 req_b  input  N_REQ  per-requester operand b, bit i for requester i.
REQ-008 req_ready  output  N_REQ  per-requester accept, at most one bit high.
REQ-009 xor_a  output  1  operand a to the shared XOR cell.
REQ-010 xor_b  output  1  operand b to the shared XOR cell.
REQ-011 xor_clk  output  1  one-cycle evaluate strobe to the XOR cell.
REQ-012 xor_out  input  1  XOR cell result.
REQ-013 rsp_valid  output  1  response available.
REQ-014 rsp_ready  input  1  response consumer accept.
REQ-015 rsp_id  output  3  index of the requester the response belongs to.
REQ-016 rsp_data  output  1  sampled XOR result.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 done_cnt  output  8  count of completed responses.

Function
REQ-019 FSM states IDLE, SETUP, STROBE, WAIT, RESP; exactly one operation in flight.
REQ-020 IDLE: grant g = first index with req_valid set, searching from (last_grant+1) mod N_REQ upward with wrap; req_ready[g] combinationally high that cycle; no valid -> all req_ready low, stay IDLE.
REQ-021 Handshake (IDLE, req_valid[g] and req_ready[g]): capture req_a[g], req_b[g], g; last_grant <= g; next state SETUP.
REQ-022 req_ready all zero in every state other than IDLE.
REQ-023 SETUP (1 cycle): xor_a/xor_b drive captured operands, xor_clk=0; -> STROBE.
REQ-024 STROBE (1 cycle): operands held, xor_clk=1; load wait counter with RES_LAT-1; -> WAIT.
REQ-025 WAIT: operands held, xor_clk=0; decrement counter each cycle; on the edge where counter is 0, rsp_data <= xor_out, rsp_id <= g; -> RESP; WAIT lasts exactly RES_LAT cycles.
REQ-026 RESP: rsp_valid=1, rsp_id/rsp_data stable; xor_a/xor_b=0; on rsp_ready=1: done_cnt <= done_cnt+1 (wraps 255 -> 0), -> IDLE; else hold.
REQ-027 Latency: handshake in cycle 0 -> rsp_valid first high in cycle 3+RES_LAT.
REQ-028 xor_a, xor_b, xor_clk are 0 in IDLE and RESP.
REQ-029 Requester deasserting req_valid after handshake has no effect on the in-flight operation.
REQ-030 rsp_ready while rsp_valid=0 is ignored; rsp_valid never drops without rsp_ready.
REQ-031 Fairness: with all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0 strictly.
REQ-032 RESP -> IDLE edge: the next grant is made in the following IDLE cycle; no back-to-back grant in RESP.

Reset
REQ-033 rst_n low at a rising edge: state IDLE, last_grant=N_REQ-1, counter 0, done_cnt 0, rsp_id 0, rsp_data 0.
REQ-034 During/after reset: req_ready 0, xor_a/xor_b/xor_clk 0, rsp_valid 0, busy 0.
REQ-035 Reset in any state aborts the in-flight operation; no response is produced for it and done_cnt is not incremented.

Verification
REQ-036 Single request: req_valid=0001, a=1, b=0, RES_LAT=1, xor_out=1 after strobe -> req_ready=0001 in cycle 0, xor_clk high in cycle 2, rsp_valid cycle 4 with rsp_id=0, rsp_data=1; done_cnt=1 after rsp_ready.
REQ-037 All four valid continuously, rsp_ready tied 1 -> grant sequence 0,1,2,3,0; each response carries matching rsp_id; done_cnt=5 after five operations.
REQ-038 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_id, rsp_data stable; req_ready stays 0000; busy=1.
REQ-039 Reset asserted during WAIT -> next cycle IDLE, all outputs 0, no rsp_valid, done_cnt unchanged at 0; first grant after reset goes to requester 0.
REQ-040 RES_LAT=3 -> WAIT lasts 3 cycles, rsp_valid in cycle 6 after handshake; xor_out sampled in final WAIT cycle only.
REQ-041 done_cnt preset via 256 operations -> value wraps to 0.
